// File: rtl/ct_f_spsram_1024x64_arb_if.sv
// Bundle of requester, response and SRAM-macro signals for the two-port SRAM arbiter.
// slave = arbiter side, master = client/macro side.
interface ct_f_spsram_1024x64_arb_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64
);
   // Handshake: a request transfers on a cycle where reqN_vld and reqN_rdy are both high;
   // rdy is a same-cycle grant, a read answers with a one-cycle rspN_vld pulse that cannot be stalled.
   logic                  req0_vld;
   logic                  req0_wr;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_wdata;
   logic [DATA_WIDTH-1:0] req0_wmask;
   logic                  req0_rdy;
   logic                  req1_vld;
   logic                  req1_wr;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_wdata;
   logic [DATA_WIDTH-1:0] req1_wmask;
   logic                  req1_rdy;
   logic                  rsp0_vld;
   logic                  rsp1_vld;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  init_done;
   logic [ADDR_WIDTH-1:0] sram_A;
   logic                  sram_CEN;
   logic                  sram_GWEN;
   logic [DATA_WIDTH-1:0] sram_WEN;
   logic [DATA_WIDTH-1:0] sram_D;
   logic [DATA_WIDTH-1:0] sram_Q;

   modport slave (
      input  req0_vld, req0_wr, req0_addr, req0_wdata, req0_wmask,
      input  req1_vld, req1_wr, req1_addr, req1_wdata, req1_wmask,
      output req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, rsp_rdata, init_done,
      output sram_A, sram_CEN, sram_GWEN, sram_WEN, sram_D,
      input  sram_Q
   );

   modport master (
      output req0_vld, req0_wr, req0_addr, req0_wdata, req0_wmask,
      output req1_vld, req1_wr, req1_addr, req1_wdata, req1_wmask,
      input  req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, rsp_rdata, init_done,
      input  sram_A, sram_CEN, sram_GWEN, sram_WEN, sram_D,
      output sram_Q
   );
endinterface

// File: rtl/ct_f_spsram_1024x64_arb.sv
// Round-robin two-requester front end for a single-port 1024x64 SRAM with active-low strobes.
// Define CT_F_SPSRAM_ARB_INIT_EN to zero-fill the whole array after every reset.
module ct_f_spsram_1024x64_arb #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64
) (
   input  logic CLK,
   input  logic RST,
   ct_f_spsram_1024x64_arb_if.slave bus_io,
   output logic dbg_state_o
);

   typedef enum logic {ST_INIT = 1'b0, ST_ARB = 1'b1} state_e;

`ifdef CT_F_SPSRAM_ARB_INIT_EN
   localparam state_e ST_RESET = ST_INIT;
`else
   localparam state_e ST_RESET = ST_ARB;
`endif

   state_e state_q, state_d;
   logic   last_grant_q, last_grant_d;
   logic   rsp0_q, rsp0_d;
   logic   rsp1_q, rsp1_d;
   logic   init_done_q, init_done_d;
   logic   gnt0, gnt1;

   logic                  cen, gwen;
   logic [ADDR_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] wen, d;

`ifdef CT_F_SPSRAM_ARB_INIT_EN
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      init_done_d  = 1'b1;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      cen          = 1'b1;
      gwen         = 1'b1;
      wen          = '1;
      a            = '0;
      d            = '0;
`ifdef CT_F_SPSRAM_ARB_INIT_EN
      cnt_d        = cnt_q;
      init_done_d  = (state_q == ST_ARB);
`endif
      if (state_q == ST_ARB) begin
         // On a tie the requester that did not win last time goes first.
         if (bus_io.req0_vld && bus_io.req1_vld) begin
            gnt0 = last_grant_q;
            gnt1 = ~last_grant_q;
         end else begin
            gnt0 = bus_io.req0_vld;
            gnt1 = bus_io.req1_vld;
         end
         if (gnt0) begin
            cen          = 1'b0;
            a            = bus_io.req0_addr;
            last_grant_d = 1'b0;
            if (bus_io.req0_wr) begin
               gwen = 1'b0;
               wen  = ~bus_io.req0_wmask;
               d    = bus_io.req0_wdata;
            end
         end else if (gnt1) begin
            cen          = 1'b0;
            a            = bus_io.req1_addr;
            last_grant_d = 1'b1;
            if (bus_io.req1_wr) begin
               gwen = 1'b0;
               wen  = ~bus_io.req1_wmask;
               d    = bus_io.req1_wdata;
            end
         end
      end
`ifdef CT_F_SPSRAM_ARB_INIT_EN
      else begin
         cen   = 1'b0;
         gwen  = 1'b0;
         wen   = '0;
         a     = cnt_q;
         cnt_d = cnt_q + ADDR_WIDTH'(1);
         if (cnt_q == '1) state_d = ST_ARB;
      end
`endif
      // Reset is asynchronous, so the combinational strobes must go quiet with it too.
      if (RST) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
         cen  = 1'b1;
         gwen = 1'b1;
         wen  = '1;
         a    = '0;
         d    = '0;
      end
      rsp0_d = gnt0 & ~bus_io.req0_wr;
      rsp1_d = gnt1 & ~bus_io.req1_wr;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_RESET;
         last_grant_q <= 1'b1;
         rsp0_q       <= 1'b0;
         rsp1_q       <= 1'b0;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rsp0_q       <= rsp0_d;
         rsp1_q       <= rsp1_d;
         init_done_q  <= init_done_d;
      end
   end

`ifdef CT_F_SPSRAM_ARB_INIT_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`endif

   assign bus_io.req0_rdy  = gnt0;
   assign bus_io.req1_rdy  = gnt1;
   assign bus_io.rsp0_vld  = rsp0_q;
   assign bus_io.rsp1_vld  = rsp1_q;
   // Macro Q is only meaningful the cycle after a read, so it is masked otherwise.
   assign bus_io.rsp_rdata = (rsp0_q | rsp1_q) ? bus_io.sram_Q : '0;
   assign bus_io.init_done = init_done_q;
   assign bus_io.sram_A    = a;
   assign bus_io.sram_CEN  = cen;
   assign bus_io.sram_GWEN = gwen;
   assign bus_io.sram_WEN  = wen;
   assign bus_io.sram_D    = d;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_ct_f_spsram_1024x64_arb.sv
// Self-checking bench: behavioural SRAM macro, table-driven request vectors and a read-data scoreboard.
module tb_ct_f_spsram_1024x64_arb;
   localparam int AW = 10;
   localparam int DW = 64;
   localparam logic [DW-1:0] ALL1 = '1;
   localparam logic [DW-1:0] ZERO = '0;

   typedef struct {
      bit            v;
      bit            w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] m;
   } op_t;

   typedef struct {
      op_t o0;
      op_t o1;
      bit  e0;
      bit  e1;
   } vec_t;

   logic clk;
   logic rst;
   logic dbg_state;

   ct_f_spsram_1024x64_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ct_f_spsram_1024x64_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .CLK        (clk),
      .RST        (rst),
      .bus_io     (bus),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- SRAM macro model ----------------
   logic [DW-1:0] sram_mem [0:1023];
   bit            sram_wr_b [0:1023];
   logic [DW-1:0] q_r;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {32'hC0DE_0000 | 32'(a), 32'h5A5A_0000 | 32'(~a)};
   endfunction

   function automatic logic [DW-1:0] cur(input logic [AW-1:0] a);
      return sram_wr_b[a] ? sram_mem[a] : pat(a);
   endfunction

   always @(posedge clk) begin
      if (!bus.sram_CEN) begin
         if (!bus.sram_GWEN) begin
            sram_mem[bus.sram_A]  <= (cur(bus.sram_A) & bus.sram_WEN) | (bus.sram_D & ~bus.sram_WEN);
            sram_wr_b[bus.sram_A] <= 1'b1;
         end else begin
            q_r <= cur(bus.sram_A);
         end
      end
   end
   assign bus.sram_Q = q_r;

   // ---------------- scoreboard state ----------------
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic [DW-1:0] ref_mem [0:1023];
   logic [DW-1:0] exp_q[$];
   bit            exp_id_q[$];
   int            exp_cyc_q[$];
   vec_t          vecs[$];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic op_t nop();
      op_t o;
      o.v = 1'b0; o.w = 1'b0; o.a = '0; o.d = '0; o.m = '0;
      return o;
   endfunction

   function automatic op_t rd(input logic [AW-1:0] a);
      op_t o;
      o = nop();
      o.v = 1'b1; o.a = a;
      return o;
   endfunction

   function automatic op_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
      op_t o;
      o.v = 1'b1; o.w = 1'b1; o.a = a; o.d = d; o.m = m;
      return o;
   endfunction

   function automatic void add(input op_t o0, input op_t o1, input bit e0, input bit e1);
      vec_t v;
      v.o0 = o0; v.o1 = o1; v.e0 = e0; v.e1 = e1;
      vecs.push_back(v);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input vec_t v);
      bus.req0_vld   = v.o0.v;
      bus.req0_wr    = v.o0.w;
      bus.req0_addr  = v.o0.a;
      bus.req0_wdata = v.o0.d;
      bus.req0_wmask = v.o0.m;
      bus.req1_vld   = v.o1.v;
      bus.req1_wr    = v.o1.w;
      bus.req1_addr  = v.o1.a;
      bus.req1_wdata = v.o1.d;
      bus.req1_wmask = v.o1.m;
   endtask

   task automatic check_rsp(input string name);
      bit e0, e1;
      e0 = exp_cyc_q.size() != 0 && exp_cyc_q[0] == cyc && exp_id_q[0] == 1'b0;
      e1 = exp_cyc_q.size() != 0 && exp_cyc_q[0] == cyc && exp_id_q[0] == 1'b1;
      chk({name, "_rsp0_vld"}, DW'(bus.rsp0_vld), DW'(e0));
      chk({name, "_rsp1_vld"}, DW'(bus.rsp1_vld), DW'(e1));
      if (e0 || e1) begin
         chk({name, "_rsp_rdata"}, bus.rsp_rdata, exp_q[0]);
         void'(exp_q.pop_front());
         void'(exp_id_q.pop_front());
         void'(exp_cyc_q.pop_front());
      end else begin
         chk({name, "_rsp_rdata_idle"}, bus.rsp_rdata, ZERO);
      end
   endtask

   task automatic check_bus(input vec_t v, input string name);
      op_t o;
      if (v.e0 || v.e1) begin
         o = v.e0 ? v.o0 : v.o1;
         chk({name, "_cen"},  DW'(bus.sram_CEN), ZERO);
         chk({name, "_A"},    DW'(bus.sram_A), DW'(o.a));
         chk({name, "_gwen"}, DW'(bus.sram_GWEN), DW'(!o.w));
         chk({name, "_wen"},  bus.sram_WEN, o.w ? ~o.m : ALL1);
         if (o.w) chk({name, "_D"}, bus.sram_D, o.d);
      end else begin
         chk({name, "_cen_idle"},  DW'(bus.sram_CEN), DW'(1'b1));
         chk({name, "_gwen_idle"}, DW'(bus.sram_GWEN), DW'(1'b1));
         chk({name, "_wen_idle"},  bus.sram_WEN, ALL1);
         chk({name, "_A_idle"},    DW'(bus.sram_A), ZERO);
         chk({name, "_D_idle"},    bus.sram_D, ZERO);
      end
   endtask

   task automatic accept(input bit id, input op_t o);
      if (o.w) begin
         ref_mem[o.a] = (ref_mem[o.a] & ~o.m) | (o.d & o.m);
      end else begin
         exp_q.push_back(ref_mem[o.a]);
         exp_id_q.push_back(id);
         exp_cyc_q.push_back(cyc + 1);
      end
   endtask

   // One cycle: drive at the falling edge, check just after, advance to the next falling edge.
   task automatic tick(input vec_t v, input string name);
      drive(v);
      #1;
      check_rsp(name);
      chk({name, "_rdy0"}, DW'(bus.req0_rdy), DW'(v.e0));
      chk({name, "_rdy1"}, DW'(bus.req1_rdy), DW'(v.e1));
      check_bus(v, name);
      if (v.e0) accept(1'b0, v.o0);
      if (v.e1) accept(1'b1, v.o1);
      @(negedge clk);
      cyc++;
   endtask

`ifdef CT_F_SPSRAM_ARB_INIT_EN
   task automatic sweep(input int n);
      for (int k = 0; k < n; k++) begin
         #1;
         chk("sweep_A", DW'(bus.sram_A), DW'(k));
         chk("sweep_strobes", DW'({bus.req0_rdy, bus.req1_rdy, bus.sram_CEN, bus.sram_GWEN,
                                   bus.init_done, dbg_state}), ZERO);
         chk("sweep_wen", bus.sram_WEN, ZERO);
         chk("sweep_D", bus.sram_D, ZERO);
         @(negedge clk);
         cyc++;
      end
   endtask
`endif

   // ---------------- timeout guard ----------------
   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running, want done");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $finish;
   end

   // ---------------- main test ----------------
   initial begin
      vec_t v;
      for (int i = 0; i < 1024; i++) begin
`ifdef CT_F_SPSRAM_ARB_INIT_EN
         ref_mem[i] = ZERO;
`else
         ref_mem[i] = pat(AW'(i));
`endif
      end

      // Reset with a pending read held on requester 0.
      rst = 1'b1;
`ifdef CT_F_SPSRAM_ARB_INIT_EN
      v.o0 = rd(10'h000);
`else
      v.o0 = rd(10'h010);
`endif
      v.o1 = nop(); v.e0 = 1'b1; v.e1 = 1'b0;
      drive(v);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rdy", DW'({bus.req0_rdy, bus.req1_rdy}), ZERO);
      chk("rst_rsp", DW'({bus.rsp0_vld, bus.rsp1_vld}), ZERO);
      chk("rst_init_done", DW'(bus.init_done), ZERO);
      chk("rst_cen_gwen", DW'({bus.sram_CEN, bus.sram_GWEN}), DW'(2'b11));
      chk("rst_wen", bus.sram_WEN, ALL1);
      chk("rst_A", DW'(bus.sram_A), ZERO);
      chk("rst_D", bus.sram_D, ZERO);
      chk("rst_rdata", bus.rsp_rdata, ZERO);
      @(negedge clk);
      rst = 1'b0;

`ifdef CT_F_SPSRAM_ARB_INIT_EN
      // Interrupt the sweep half way and make sure it starts over.
      sweep(10'h200);
      #1;
      chk("midinit_A", DW'(bus.sram_A), DW'(10'h200));
      rst = 1'b1;
      #1;
      chk("midinit_cen", DW'(bus.sram_CEN), DW'(1'b1));
      chk("midinit_init_done", DW'(bus.init_done), ZERO);
      @(negedge clk);
      rst = 1'b0;
      sweep(1024);
      chk("init_done_before_edge", DW'(bus.init_done), ZERO);
`else
      chk("init_done_before_edge", DW'(bus.init_done), ZERO);
`endif
      tick(v, "first_read");
      chk("init_done_after", DW'(bus.init_done), DW'(1'b1));
      chk("dbg_state_arb", DW'(dbg_state), DW'(1'b1));

      // Vector table (last grant is requester 0 at this point).
      add(nop(), nop(), 1'b0, 1'b0);
      add(nop(), wr(10'h155, ALL1, ALL1), 1'b0, 1'b1);
      add(nop(), wr(10'h155, ZERO, 64'h0000_0000_FFFF_0000), 1'b0, 1'b1);
      add(nop(), rd(10'h155), 1'b0, 1'b1);
      add(nop(), nop(), 1'b0, 1'b0);
      add(wr(10'h2A0, 64'h1111, ALL1), nop(), 1'b1, 1'b0);
      add(rd(10'h2A0), nop(), 1'b1, 1'b0);
      add(wr(10'h2A0, 64'h2222, ALL1), nop(), 1'b1, 1'b0);
      add(rd(10'h2A0), nop(), 1'b1, 1'b0);
      add(nop(), nop(), 1'b0, 1'b0);
      add(nop(), rd(10'h155), 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         add(rd(10'h2A0), rd(10'h155), 1'b1, 1'b0);
         add(rd(10'h2A0), rd(10'h155), 1'b0, 1'b1);
      end
      add(wr(10'h300, 64'hAAAA_5555_AAAA_5555, ALL1), wr(10'h301, 64'hBBBB_CCCC_DDDD_EEEE, ALL1), 1'b1, 1'b0);
      add(wr(10'h300, 64'hAAAA_5555_AAAA_5555, ALL1), wr(10'h301, 64'hBBBB_CCCC_DDDD_EEEE, ALL1), 1'b0, 1'b1);
      add(rd(10'h300), rd(10'h301), 1'b1, 1'b0);
      add(rd(10'h300), rd(10'h301), 1'b0, 1'b1);
      add(nop(), nop(), 1'b0, 1'b0);
      add(wr(10'h300, ZERO, ZERO), nop(), 1'b1, 1'b0);
      add(rd(10'h300), nop(), 1'b1, 1'b0);
      add(nop(), rd(10'h000), 1'b0, 1'b1);
      add(rd(10'h3FF), nop(), 1'b1, 1'b0);
      add(nop(), nop(), 1'b0, 1'b0);
      add(nop(), nop(), 1'b0, 1'b0);
      foreach (vecs[i]) tick(vecs[i], $sformatf("vec%0d", i));

      // Reset while a read response is pending: the response must vanish at once.
      v.o0 = rd(10'h2A0); v.o1 = nop(); v.e0 = 1'b1; v.e1 = 1'b0;
      drive(v);
      #1;
      chk("midtraffic_rdy0", DW'(bus.req0_rdy), DW'(1'b1));
      @(posedge clk);
      #1;
      chk("midtraffic_rsp_pending", DW'(bus.rsp0_vld), DW'(1'b1));
      chk("midtraffic_rdata_pending", bus.rsp_rdata, ref_mem[10'h2A0]);
      rst = 1'b1;
      #1;
      chk("midtraffic_rsp_dropped", DW'(bus.rsp0_vld), ZERO);
      chk("midtraffic_rdata", bus.rsp_rdata, ZERO);
      chk("midtraffic_rdy0", DW'(bus.req0_rdy), ZERO);
      chk("midtraffic_cen", DW'(bus.sram_CEN), DW'(1'b1));
      chk("midtraffic_init_done", DW'(bus.init_done), ZERO);
      v.o0 = rd(10'h2A0); v.o1 = rd(10'h155); v.e0 = 1'b1; v.e1 = 1'b0;
      drive(v);
      @(negedge clk);
      rst = 1'b0;
`ifdef CT_F_SPSRAM_ARB_INIT_EN
      for (int i = 0; i < 1024; i++) ref_mem[i] = ZERO;
      sweep(1024);
`endif

      // Contention straight out of reset: requester 0 wins the first tie.
      vecs.delete();
      add(rd(10'h2A0), rd(10'h155), 1'b1, 1'b0);
      add(rd(10'h2A0), rd(10'h155), 1'b0, 1'b1);
      add(rd(10'h2A0), rd(10'h155), 1'b1, 1'b0);
      add(nop(), nop(), 1'b0, 1'b0);
      add(nop(), nop(), 1'b0, 1'b0);
      foreach (vecs[i]) tick(vecs[i], $sformatf("post_rst%0d", i));
      chk("post_rst_init_done", DW'(bus.init_done), DW'(1'b1));
      chk("scoreboard_drained", DW'(exp_q.size()), ZERO);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
